alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be a power of two >= 8.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 valid_i  input  1  request valid.
REQ-005 ready_o  output  1  block can accept a request this cycle.
REQ-006 operator_i  input  4  operation code, sampled at accept.
REQ-007 operand_a_i  input  WIDTH  first operand, sampled at accept.
REQ-008 operand_b_i  input  WIDTH  second operand, sampled at accept.
REQ-009 valid_o  output  1  result valid.
REQ-010 ready_i  input  1  consumer takes the result this cycle.
REQ-011 result_o  output  WIDTH  registered result.
REQ-012 comparison_result_o  output  1  registered compare flag.
REQ-013 busy_o  output  1  iterative operation in progress.

Function
REQ-014 Accept SHALL occur when valid_i and ready_o are both high; operator and operands are captured into internal registers at that edge.
REQ-015 Transfer out SHALL occur when valid_o and ready_i are both high.
REQ-016 The FSM SHALL have states IDLE, ITER and DONE. ready_o = (state==IDLE); valid_o = (state==DONE); busy_o = (state==ITER).
REQ-017 IDLE + accept of a single-cycle op (0000-1101) SHALL go to DONE with the result registered; latency 1 cycle.
REQ-018 IDLE + accept of 1110 or 1111 SHALL go to ITER with iteration counter = 0.
REQ-019 ITER SHALL process one operand bit per cycle and go to DONE after exactly WIDTH cycles; latency WIDTH+1 cycles.
REQ-020 DONE SHALL hold result_o and comparison_result_o stable until transfer out, then return to IDLE; throughput is at most one request per 2 cycles.
REQ-021 Ops, result_o (comparison_result_o = 0 unless stated otherwise):
 - 0000 ADD a+b, modulo 2^WIDTH; 0001 SUB a-b, modulo 2^WIDTH.
 - 0010 XOR; 0011 OR; 0100 AND.
 - 0101 SRA, arithmetic right shift; 0110 SRL, logical right shift; 0111 SLL, left shift. The shift amount is the low log2(WIDTH) bits of b.
 - 1000 LTS: a<b signed. 1001 LTU: a<b unsigned. 1010 GES: a>=b signed. 1011 GEU: a>=b unsigned. 1100 EQ: a==b. 1101 NE: a!=b. For 1000-1101, result_o = zero-extended flag and comparison_result_o = flag.
 - 1110 MUL: low WIDTH bits of unsigned a*b, by iterative shift-add.
 - 1111 DIVU: unsigned quotient a/b, by restoring division.
REQ-022 DIVU with b=0 SHALL return all ones and SHALL still take WIDTH+1 cycles.
REQ-023 valid_i while ready_o is low SHALL be ignored; the request is not captured.
REQ-024 Changes on the operand and operator inputs after accept SHALL NOT affect the result in flight.

Reset
REQ-025 While rst_i is high at an edge: state = IDLE; valid_o = 0, busy_o = 0, result_o = 0, comparison_result_o = 0, iteration counter = 0. ready_o is therefore 1 in the first cycle after reset.
REQ-026 Reset asserted in ITER or DONE SHALL abort the operation and discard the result; no valid_o pulse follows.
REQ-027 A request with valid_i high in the same cycle as rst_i SHALL NOT be accepted.

Verification (WIDTH=32)
REQ-028 ADD, a=0xFFFFFFFF, b=1, ready_i=1 -> valid_o high 1 cycle after accept; result_o = 0; comparison_result_o = 0.
REQ-029 a=0xFFFFFFFF, b=1 -> LTS: result_o = 1, comparison_result_o = 1; LTU: both 0; GEU: both 1.
REQ-030 SRA, a=0x80000000, b=0x24 -> result_o = 0xF8000000. SRL with the same operands -> result_o = 0x08000000.
REQ-031 MUL, a=0x00010003, b=5 -> busy_o high for 32 cycles, valid_o high 33 cycles after accept, result_o = 0x0005000F. DIVU 100/7 -> 14. DIVU 5/0 -> 0xFFFFFFFF.
REQ-032 ready_i low for 5 cycles in DONE -> result_o stable and ready_o low throughout; a valid_i pulse in that window is not captured; with ready_i high the block returns to IDLE on the next cycle.
REQ-033 rst_i pulsed at ITER cycle 10 of a MUL -> in the next cycle state = IDLE, ready_o = 1, valid_o = 0; no result appears later.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq.
// The master drives requests and takes results; the slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       operator_i;
  logic [WIDTH-1:0] operand_a_i;
  logic [WIDTH-1:0] operand_b_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             comparison_result_o;
  logic             busy_o;

  modport master (
    output valid_i, operator_i, operand_a_i, operand_b_i, ready_i,
    input  ready_o, valid_o, result_o, comparison_result_o, busy_o
  );

  modport slave (
    input  valid_i, operator_i, operand_a_i, operand_b_i, ready_i,
    output ready_o, valid_o, result_o, comparison_result_o, busy_o
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops done in 1 cycle, MUL/DIVU iterate one bit per cycle (WIDTH+1).
// One request in flight; ready only in IDLE, result held in DONE until the consumer takes it.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    cnt_q;
  logic             is_mul_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [WIDTH-1:0] result_q;
  logic             cmp_q;
  logic             ready_c, valid_c, busy_c;

  logic             is_iter_op;
  logic [WIDTH-1:0] single_res;
  logic             single_cmp;
  logic [WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_d, div_quo_d;

  assign is_iter_op = (bus.operator_i[3:1] == 3'b111);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    valid_c = 1'b0;
    busy_c  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.valid_i) state_d = is_iter_op ? ITER : DONE;
      end
      ITER: begin
        busy_c = 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        valid_c = 1'b1;
        if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle ops are evaluated straight from the inputs and registered at accept.
  always_comb begin
    logic [SW-1:0] shamt;
    logic          lts, ltu, eq;
    shamt      = bus.operand_b_i[SW-1:0];
    lts        = $signed(bus.operand_a_i) < $signed(bus.operand_b_i);
    ltu        = bus.operand_a_i < bus.operand_b_i;
    eq         = bus.operand_a_i == bus.operand_b_i;
    single_res = '0;
    single_cmp = 1'b0;
    case (bus.operator_i)
      4'b0000: single_res = bus.operand_a_i + bus.operand_b_i;
      4'b0001: single_res = bus.operand_a_i - bus.operand_b_i;
      4'b0010: single_res = bus.operand_a_i ^ bus.operand_b_i;
      4'b0011: single_res = bus.operand_a_i | bus.operand_b_i;
      4'b0100: single_res = bus.operand_a_i & bus.operand_b_i;
      4'b0101: single_res = $signed(bus.operand_a_i) >>> shamt;
      4'b0110: single_res = bus.operand_a_i >> shamt;
      4'b0111: single_res = bus.operand_a_i << shamt;
      4'b1000: single_cmp = lts;
      4'b1001: single_cmp = ltu;
      4'b1010: single_cmp = ~lts;
      4'b1011: single_cmp = ~ltu;
      4'b1100: single_cmp = eq;
      4'b1101: single_cmp = ~eq;
      default: single_cmp = 1'b0;
    endcase
    if (bus.operator_i[3] && !is_iter_op) single_res = {{(WIDTH-1){1'b0}}, single_cmp};
  end

  // Iteration step. MUL: acc += a when b[0], a<<=1, b>>=1.
  // DIVU: a_q shifts dividend bits out of its MSB into acc (remainder) and quotient bits in at its LSB.
  // With b=0 every trial subtract succeeds, so the quotient naturally ends up all ones.
  assign mul_acc_d = acc_q + (b_q[0] ? a_q : '0);
  assign rem_sh    = {acc_q, a_q[WIDTH-1]};
  assign div_ge    = rem_sh >= {1'b0, b_q};
  assign div_rem_d = div_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
  assign div_quo_d = {a_q[WIDTH-2:0], div_ge};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cmp_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.valid_i) begin
          is_mul_q <= ~bus.operator_i[0];
          a_q      <= bus.operand_a_i;
          b_q      <= bus.operand_b_i;
          acc_q    <= '0;
          cnt_q    <= '0;
          if (!is_iter_op) begin
            result_q <= single_res;
            cmp_q    <= single_cmp;
          end
        end
        ITER: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_mul_q) begin
            acc_q <= mul_acc_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else begin
            acc_q <= div_rem_d;
            a_q   <= div_quo_d;
          end
          if (cnt_q == CNT_LAST) begin
            result_q <= is_mul_q ? mul_acc_d : div_quo_d;
            cmp_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o             = ready_c;
  assign bus.valid_o             = valid_c;
  assign bus.busy_o              = busy_c;
  assign bus.result_o            = result_q;
  assign bus.comparison_result_o = cmp_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): golden model results queued at accept, compared at transfer.
module tb_alu_seq;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        cmp;
  } exp_t;
  exp_t sb[$];

  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq #(.WIDTH(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c);
    logic [63:0] p;
    r = '0;
    c = 1'b0;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a ^ b;
      4'h3: r = a | b;
      4'h4: r = a & b;
      4'h5: r = $signed(a) >>> b[4:0];
      4'h6: r = a >> b[4:0];
      4'h7: r = a << b[4:0];
      4'h8: c = $signed(a) < $signed(b);
      4'h9: c = a < b;
      4'hA: c = $signed(a) >= $signed(b);
      4'hB: c = a >= b;
      4'hC: c = a == b;
      4'hD: c = a != b;
      4'hE: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      default: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endcase
    if (op >= 4'h8 && op <= 4'hD) r = {31'd0, c};
  endfunction

  task automatic wait_ready();
    int to = 0;
    while (!bus.ready_o && to < 200) begin
      @(negedge clk);
      to++;
    end
    check_eq("ready_wait", 32'(bus.ready_o), 32'd1);
  endtask

  // Issue one request at a negedge; hold ready_i low for 'hold' cycles once the result is up.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    int          lat, busy_n;
    logic [31:0] r0, er;
    logic        ec;
    exp_t        e;
    wait_ready();
    bus.ready_i     = (hold == 0);
    bus.valid_i     = 1'b1;
    bus.operator_i  = op;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    @(posedge clk);
    model(op, a, b, er, ec);
    sb.push_back('{res: er, cmp: ec});
    @(negedge clk);
    bus.valid_i     = 1'b0;
    bus.operator_i  = 4'($urandom);
    bus.operand_a_i = $urandom;
    bus.operand_b_i = $urandom;
    lat    = 1;
    busy_n = 0;
    while (!bus.valid_o && lat < 100) begin
      busy_n += int'(bus.busy_o);
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), (op >= 4'hE) ? 32'd33 : 32'd1);
    if (op >= 4'hE) check_eq({tag, "_busy"}, 32'(busy_n), 32'd32);
    r0 = bus.result_o;
    for (int i = 0; i < hold; i++) begin
      check_eq({tag, "_hold_res"}, bus.result_o, r0);
      check_eq({tag, "_hold_rdy"}, 32'(bus.ready_o), 32'd0);
      bus.valid_i    = (i == 1);
      bus.operator_i = 4'h0;
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    check_eq({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq({tag, "_res"}, bus.result_o, e.res);
      check_eq({tag, "_cmp"}, 32'(bus.comparison_result_o), 32'(e.cmp));
    end
    @(negedge clk);
    check_eq({tag, "_idle_rdy"}, 32'(bus.ready_o), 32'd1);
    check_eq({tag, "_idle_vld"}, 32'(bus.valid_o), 32'd0);
  endtask

  initial begin
    int vld_seen;
    rst             = 1'b1;
    bus.valid_i     = 1'b0;
    bus.ready_i     = 1'b1;
    bus.operator_i  = 4'h0;
    bus.operand_a_i = '0;
    bus.operand_b_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", 32'(bus.ready_o), 32'd1);
    check_eq("rst_valid", 32'(bus.valid_o), 32'd0);
    check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
    check_eq("rst_result", bus.result_o, 32'd0);
    check_eq("rst_cmp", 32'(bus.comparison_result_o), 32'd0);

    do_op("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("lts", 4'h8, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("ltu", 4'h9, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("ges", 4'hA, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("geu", 4'hB, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("eq", 4'hC, 32'h1234_5678, 32'h1234_5678, 0);
    do_op("ne", 4'hD, 32'h1234_5678, 32'h1234_5678, 0);
    do_op("sub", 4'h1, 32'd3, 32'd5, 0);
    do_op("xor", 4'h2, 32'hF0F0_1234, 32'h0FF0_4321, 0);
    do_op("or", 4'h3, 32'hF000_0001, 32'h0000_0F10, 0);
    do_op("and", 4'h4, 32'hF0F0_FFFF, 32'h3C3C_00F0, 0);
    do_op("sra", 4'h5, 32'h8000_0000, 32'h0000_0024, 0);
    do_op("srl", 4'h6, 32'h8000_0000, 32'h0000_0024, 0);
    do_op("sll", 4'h7, 32'h0000_00F1, 32'h0000_003F, 0);
    do_op("mul", 4'hE, 32'h0001_0003, 32'd5, 0);
    do_op("mul_big", 4'hE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("divu", 4'hF, 32'd100, 32'd7, 0);
    do_op("divu_zero", 4'hF, 32'd5, 32'd0, 0);
    do_op("divu_max", 4'hF, 32'hFFFF_FFFF, 32'd3, 0);
    do_op("hold_add", 4'h0, 32'd10, 32'd20, 5);
    do_op("hold_mul", 4'hE, 32'd1234, 32'd4321, 5);

    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      do_op("rand", op, a, b, i % 4);
    end

    // Abort a MUL mid-iteration.
    wait_ready();
    bus.valid_i     = 1'b1;
    bus.operator_i  = 4'hE;
    bus.operand_a_i = 32'd77;
    bus.operand_b_i = 32'd99;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("abort_busy_before", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_ready", 32'(bus.ready_o), 32'd1);
    check_eq("abort_valid", 32'(bus.valid_o), 32'd0);
    check_eq("abort_busy", 32'(bus.busy_o), 32'd0);
    vld_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      vld_seen += int'(bus.valid_o) + int'(bus.busy_o);
    end
    check_eq("abort_no_result", 32'(vld_seen), 32'd0);

    // A request presented during reset must be dropped.
    rst             = 1'b1;
    bus.valid_i     = 1'b1;
    bus.operator_i  = 4'h0;
    bus.operand_a_i = 32'd1;
    bus.operand_b_i = 32'd2;
    @(negedge clk);
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clk);
    check_eq("rstreq_valid", 32'(bus.valid_o), 32'd0);
    check_eq("rstreq_ready", 32'(bus.ready_o), 32'd1);
    check_eq("rstreq_result", bus.result_o, 32'd0);

    do_op("post_reset_add", 4'h0, 32'd40, 32'd2, 0);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
